// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
interface serial_adder_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic             sub;
   logic             cin;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, sub, cin, a, b,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, sub, cin, a, b,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop,
// one result bit per clock, LSB first, start/busy/done handshake.
// Subtraction is A + ~B + 1; cout is the final carry (not-borrow for sub);
// ovf is the carry into the MSB xor the carry out of the MSB.
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_adder_if.slave bus
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             c;
   logic [CNT_W-1:0] cnt;

   logic             s;
   logic             c_next;
   logic [WIDTH-1:0] res_next;

   // Full-adder cell on the current LSBs and the shift-in of its sum bit.
   always_comb begin
      s        = a_sr[0] ^ b_sr[0] ^ c;
      c_next   = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
      res_next = res_sr >> 1;
      res_next[WIDTH-1] = s;
   end

   // Control FSM, datapath shift registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         a_sr     <= '0;
         b_sr     <= '0;
         res_sr   <= '0;
         c        <= 1'b0;
         cnt      <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.sum  <= '0;
         bus.cout <= 1'b0;
         bus.ovf  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  a_sr     <= bus.a;
                  b_sr     <= bus.sub ? ~bus.b : bus.b;
                  c        <= bus.sub | bus.cin;
                  cnt      <= '0;
                  bus.busy <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               c      <= c_next;
               res_sr <= res_next;
               cnt    <= cnt + 1'b1;
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  // On the MSB cycle the current c is the carry into the MSB,
                  // so overflow is formed directly rather than via a saved copy.
                  bus.sum  <= res_next;
                  bus.cout <= c_next;
                  bus.ovf  <= c ^ c_next;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               bus.done <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               bus.busy <= 1'b0;
               bus.done <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
